// File: rtl/rbcp_axil_master.sv
// rbcp_axil_master: bridges SiTCP RBCP byte accesses onto single-beat AXI4-Lite
// master transactions. Each RBCP byte maps to one lane of an aligned 32-bit word.
// Optional feature: define RBCP_TIMEOUT_EN to force completion of a stalled
// transaction after TIMEOUT busy cycles (read data 8'hFF, error counted).
`timescale 1ns/1ps
module rbcp_axil_master #(
  parameter int unsigned           AXI_ADDR_W = 32,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rbcp_act,
  input  logic [31:0]           rbcp_addr,
  input  logic                  rbcp_we,
  input  logic [7:0]            rbcp_wd,
  input  logic                  rbcp_re,
  output logic [7:0]            rbcp_rd,
  output logic                  rbcp_ack,
  output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [7:0]            err_cnt
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK} state_t;

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("rbcp_axil_master: TIMEOUT must be in 1..255");
  end

  state_t                state_q, state_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d, ack_q, ack_d;
  logic                  act_ok_q, act_ok_d;
  logic [7:0]            rd_q, rd_d, wd_q, wd_d, err_q, err_d;
  logic [3:0]            strb_q, strb_d;
  logic [1:0]            off_q, off_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d, addr_c;
  logic [31:0]           word_addr_c;
  logic                  err_inc_c;
  logic                  tmo_c;

  // Word-aligned AXI address for the incoming RBCP byte address.
  always_comb begin
    word_addr_c = {rbcp_addr[31:2], 2'b00};
    addr_c      = BASE_ADDR + AXI_ADDR_W'(word_addr_c);
  end

`ifdef RBCP_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       busy_c;

  // Busy-cycle counter: zero in IDLE/ACK, so it restarts on every new transaction.
  always_comb begin
    busy_c    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                (state_q == RD_REQ) || (state_q == RD_RESP);
    tmo_cnt_d = busy_c ? tmo_cnt_q + 8'd1 : 8'd0;
    tmo_c     = busy_c && (tmo_cnt_d == 8'(TIMEOUT));
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= 8'd0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_c = 1'b0;
`endif

  // Next-state and next-output logic; outputs are registered from the _d values.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ack_d     = 1'b0;
    act_ok_d  = act_ok_q & rbcp_act;
    rd_d      = rd_q;
    wd_d      = wd_q;
    strb_d    = strb_q;
    off_d     = off_q;
    addr_d    = addr_q;
    err_inc_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        act_ok_d = 1'b1;
        if (rbcp_act && rbcp_we) begin
          state_d   = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          addr_d    = addr_c;
          wd_d      = rbcp_wd;
          strb_d    = 4'b0001 << rbcp_addr[1:0];
          off_d     = rbcp_addr[1:0];
        end else if (rbcp_act && rbcp_re) begin
          state_d   = RD_REQ;
          arvalid_d = 1'b1;
          addr_d    = addr_c;
          off_d     = rbcp_addr[1:0];
        end
      end
      WR_REQ: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          state_d   = ACK;
          bready_d  = 1'b0;
          ack_d     = act_ok_d;
          err_inc_c = (m_axi_bresp != 2'b00);
        end
      end
      RD_REQ: begin
        if (m_axi_arready) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid) begin
          state_d   = ACK;
          rready_d  = 1'b0;
          rd_d      = m_axi_rdata[{off_q, 3'b000} +: 8];
          ack_d     = act_ok_d;
          err_inc_c = (m_axi_rresp != 2'b00);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Forced completion of a stalled transaction; a normal completion wins.
    if (tmo_c && state_d != ACK) begin
      if (state_q == RD_REQ || state_q == RD_RESP) rd_d = 8'hFF;
      state_d   = ACK;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      ack_d     = act_ok_d;
      err_inc_c = 1'b1;
    end
    err_d = (err_inc_c && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      act_ok_q  <= 1'b0;
      rd_q      <= 8'd0;
      wd_q      <= 8'd0;
      strb_q    <= 4'd0;
      off_q     <= 2'd0;
      addr_q    <= '0;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      act_ok_q  <= act_ok_d;
      rd_q      <= rd_d;
      wd_q      <= wd_d;
      strb_q    <= strb_d;
      off_q     <= off_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  assign rbcp_rd       = rd_q;
  assign rbcp_ack      = ack_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = {4{wd_q}};
  assign m_axi_wstrb   = strb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign err_cnt       = err_q;

endmodule
